// File: rtl/shift_pkg.sv
// Shared types and width helpers for the shift execute stage.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_t;

  function automatic int shamt_width(input int n);
    return $clog2(n);
  endfunction

  localparam int DEFAULT_N = 32;
  localparam int SHAMT_W   = shamt_width(DEFAULT_N);

endpackage

// File: rtl/shift_core.sv
// Combinational shift unit; SRA and ROR are both built on the srl output.
module shift_core
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]         a,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic [1:0]           op,
  output logic [N-1:0]         result
);

  localparam int SW = $clog2(N);

  logic [N-1:0] srl_out;
  logic [N-1:0] sign_mask;
  logic [N-1:0] rol_part;
  logic [SW:0]  rot_amt;

  srl #(.N(N)) u_srl (
    .in    (a),
    .shamt (shamt),
    .out   (srl_out)
  );

  assign sign_mask = a[N-1] ? ~({N{1'b1}} >> shamt) : '0;
  assign rot_amt   = (SW+1)'(N) - {1'b0, shamt};

  // A zero rotate must not pull in an N-bit left shift of a.
  assign rol_part  = (shamt == '0) ? '0 : (a << rot_amt);

  always_comb begin
    result = srl_out;
    case (shift_op_t'(op))
      SHIFT_SLL: result = a << shamt;
      SHIFT_SRL: result = srl_out;
      SHIFT_SRA: result = srl_out | sign_mask;
      SHIFT_ROR: result = srl_out | rol_part;
      default:   result = srl_out;
    endcase
  end

endmodule

// File: rtl/srl.sv
// Logarithmic barrel shifter: logical right shift with zero fill.
module srl #(
  parameter int N = 32
) (
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         out
);

  localparam int SW = $clog2(N);

  logic [N-1:0] stage [SW+1];

  assign stage[0] = in;

  // Each level conditionally shifts by the power of two matching its shamt bit.
  for (genvar i = 0; i < SW; i++) begin : g_stage
    assign stage[i+1] = shamt[i] ? (stage[i] >> (1 << i)) : stage[i];
  end

  assign out = stage[SW];

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift execute stage with valid/ready on both sides.
module shift_exec_stage
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int TAGW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [N-1:0]         in_a,
  input  logic [$clog2(N)-1:0] in_shamt,
  input  logic [TAGW-1:0]      in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_result,
  output logic [TAGW-1:0]      out_tag,
  output logic [1:0]           occupancy
);

  localparam int SW = $clog2(N);

  logic            valid1, valid2;
  logic            valid1_nxt, valid2_nxt;
  logic [1:0]      op1;
  logic [N-1:0]    a1;
  logic [SW-1:0]   shamt1;
  logic [TAGW-1:0] tag1;
  logic [N-1:0]    core_result;
  logic            s2_free, s1_adv, accept, out_xfer;

  assign s2_free   = !valid2 || out_ready;
  assign s1_adv    = valid1 && s2_free;
  assign in_ready  = rst_n && !flush && (!valid1 || s1_adv);
  assign accept    = in_valid && in_ready;
  assign out_xfer  = valid2 && out_ready;
  assign out_valid = valid2;

  shift_core #(.N(N)) u_core (
    .a      (a1),
    .shamt  (shamt1),
    .op     (op1),
    .result (core_result)
  );

  // Next valids are shared by the valid flops and occupancy so they never disagree.
  always_comb begin
    valid1_nxt = valid1;
    valid2_nxt = valid2;
    if (flush) begin
      valid1_nxt = 1'b0;
      valid2_nxt = 1'b0;
    end else begin
      if (accept)        valid1_nxt = 1'b1;
      else if (s1_adv)   valid1_nxt = 1'b0;
      if (s1_adv)        valid2_nxt = 1'b1;
      else if (out_xfer) valid2_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1    <= 1'b0;
      valid2    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      valid1    <= valid1_nxt;
      valid2    <= valid2_nxt;
      occupancy <= {1'b0, valid1_nxt} + {1'b0, valid2_nxt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1    <= '0;
      a1     <= '0;
      shamt1 <= '0;
      tag1   <= '0;
    end else if (accept) begin
      op1    <= in_op;
      a1     <= in_a;
      shamt1 <= in_shamt;
      tag1   <= in_tag;
    end
  end

  // Result holds while stalled, keeping out_result stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (s1_adv && !flush) begin
      out_result <= core_result;
      out_tag    <= tag1;
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed self-checking bench for shift_exec_stage.
module tb_shift_exec_stage;

  localparam int N    = 32;
  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [N-1:0]    in_a;
  logic [4:0]      in_shamt;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_result;
  logic [TAGW-1:0] out_tag;
  logic [1:0]      occupancy;

  int checks = 0;
  int errors = 0;

  shift_exec_stage #(.N(N), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                               input logic [4:0] s, input logic [4:0] t);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_shamt = s;
    in_tag   = t;
  endtask

  task automatic checkResult(input string name, input logic [31:0] res, input logic [4:0] t);
    checkOutput({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({name, "_result"}, out_result, res);
    checkOutput({name, "_tag"}, {27'b0, out_tag}, {27'b0, t});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
    #2;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_occupancy", {30'b0, occupancy}, 32'd0);
    checkOutput("rst_result", out_result, 32'h0);
    checkOutput("rst_tag", {27'b0, out_tag}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single SRA op: result two edges after acceptance.
    @(negedge clk);
    applyStimulus(1'b1, 2'b10, 32'h8000_00F0, 5'd4, 5'd3);
    #1 checkOutput("single_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    checkOutput("single_edge1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    checkResult("single_sra", 32'hF800_000F, 5'd3);
    @(negedge clk);
    checkOutput("single_drained", {31'b0, out_valid}, 32'd0);

    // Back-to-back ops at full throughput.
    applyStimulus(1'b1, 2'b00, 32'h0000_0001, 5'd31, 5'd1);
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd31, 5'd2);
    @(negedge clk);
    checkOutput("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(1'b1, 2'b11, 32'h0000_0001, 5'd1, 5'd3);
    checkResult("b2b_sll", 32'h8000_0000, 5'd1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    checkResult("b2b_srl", 32'h0000_0001, 5'd2);
    @(negedge clk);
    checkResult("b2b_ror", 32'h8000_0000, 5'd3);
    @(negedge clk);
    checkOutput("b2b_drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: two entries fill, third waits.
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 32'h0000_0005, 5'd2, 5'd4);
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 32'h0000_0080, 5'd4, 5'd5);
    #1 checkOutput("bp_ready_b", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 2'b11, 32'h0000_000F, 5'd4, 5'd6);
    #1 checkOutput("bp_occupancy", {30'b0, occupancy}, 32'd2);
    checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
    checkResult("bp_hold1", 32'h0000_0014, 5'd4);
    @(negedge clk);
    checkResult("bp_hold2", 32'h0000_0014, 5'd4);
    checkOutput("bp_occupancy2", {30'b0, occupancy}, 32'd2);
    out_ready = 1'b1;
    #1 checkOutput("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    checkResult("bp_out_b", 32'h0000_0008, 5'd5);
    @(negedge clk);
    checkResult("bp_out_c", 32'hF000_0000, 5'd6);
    @(negedge clk);
    checkOutput("bp_drained", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_occ_zero", {30'b0, occupancy}, 32'd0);

    // Zero shift returns the operand for every op.
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) checkResult($sformatf("zero_op%0d", i - 2), 32'hDEAD_BEEF, 5'(i + 8));
      if (i < 4) applyStimulus(1'b1, 2'(i), 32'hDEAD_BEEF, 5'd0, 5'(i + 10));
      else       applyStimulus(1'b0, 2'd0, 32'h0, 5'd0, 5'd0);
      @(negedge clk);
    end

    // Flush with both stages occupied.
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 32'h0000_0001, 5'd1, 5'd7);
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 32'h0000_0001, 5'd2, 5'd8);
    @(negedge clk);
    checkOutput("fl_occ_before", {30'b0, occupancy}, 32'd2);
    flush = 1'b1;
    applyStimulus(1'b1, 2'b01, 32'h0000_FFFF, 5'd4, 5'd12);
    out_ready = 1'b1;
    #1 checkOutput("fl_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    checkOutput("fl_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("fl_occupancy", {30'b0, occupancy}, 32'd0);
    applyStimulus(1'b1, 2'b10, 32'hF000_0000, 5'd4, 5'd9);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    checkResult("fl_after", 32'hFF00_0000, 5'd9);
    @(negedge clk);
    checkOutput("fl_no_stray", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset with two entries in flight.
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 32'h0000_0003, 5'd4, 5'd13);
    @(negedge clk);
    applyStimulus(1'b1, 2'b00, 32'h0000_0003, 5'd8, 5'd14);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    checkOutput("rs_occ_before", {30'b0, occupancy}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rs_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rs_occupancy", {30'b0, occupancy}, 32'd0);
    checkOutput("rs_result", out_result, 32'h0);
    checkOutput("rs_tag", {27'b0, out_tag}, 32'd0);
    checkOutput("rs_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 2'b01, 32'h0000_0100, 5'd8, 5'd15);
    @(negedge clk);
    applyStimulus(1'b0, 2'b00, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    checkResult("rs_fresh_srl", 32'h0000_0001, 5'd15);
    @(negedge clk);
    checkOutput("rs_drained", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
